// File: rtl/regfile_hex_display.sv
// rtl/regfile_hex_display.sv - sweeps the 8x8 register file into a shadow copy and scans it onto an 8-digit hex display
module regfile_hex_display #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] rd_q,
  output logic [2:0] rd_sel,
  input  logic       page,
  input  logic       hold,
  output logic [7:0] led_en,
  output logic [7:0] seg
);

  logic [2:0]       rd_ptr;
  logic [7:0]       shadow [8];
  logic [CNT_W-1:0] div_cnt;
  logic [2:0]       digit;
  logic             tick;
  logic [2:0]       reg_idx;
  logic [3:0]       nibble;
  logic [6:0]       seg_bits;
  logic             dp;

  // Active-low segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  assign rd_sel   = rd_ptr;
  assign tick     = (div_cnt == CNT_W'(SCAN_DIV - 1));
  assign reg_idx  = {page, digit[2:1]};
  assign nibble   = digit[0] ? shadow[reg_idx][7:4] : shadow[reg_idx][3:0];
  assign seg_bits = hex7(nibble);
  assign dp       = ~(page & digit[0]);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_ptr  <= 3'd0;
      div_cnt <= '0;
      digit   <= 3'd0;
      led_en  <= 8'hFF;
      seg     <= 8'hFF;
      for (int i = 0; i < 8; i++) shadow[i] <= 8'h00;
    end else begin
      if (!hold) begin
        shadow[rd_ptr] <= rd_q;
        rd_ptr         <= rd_ptr + 3'd1;
      end
      div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
      if (tick) digit <= digit + 3'd1;
      // Outputs use the pre-edge digit and shadow, so rd_q never bypasses to seg
      led_en <= ~(8'b1 << digit);
      seg    <= {dp, seg_bits};
    end
  end

endmodule

// File: tb/tb_regfile_hex_display.sv
// tb/tb_regfile_hex_display.sv - scoreboard bench with a behavioural regfile and display model
module tb_regfile_hex_display;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] rd_q;
  logic [2:0] rd_sel;
  logic       page;
  logic       hold;
  logic [7:0] led_en;
  logic [7:0] seg;

  logic [7:0] regs [8];
  assign rd_q = regs[rd_sel];

  regfile_hex_display #(.SCAN_DIV(SCAN_DIV), .CNT_W(2)) dut (
    .clk(clk), .clr(clr), .rd_q(rd_q), .rd_sel(rd_sel),
    .page(page), .hold(hold), .led_en(led_en), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] led;
    logic [7:0] sg;
    logic [2:0] sel;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
  endtask

  // Reference model: digit position is elapsed edges / SCAN_DIV, the shadow is a
  // plain array refreshed one entry per unheld edge.
  int         m_n;
  int         m_ptr;
  logic [7:0] m_shadow [8];

  always @(posedge clk) begin
    exp_t e;
    int d, r;
    logic [3:0] nib;
    if (clr) begin
      m_n = 0;
      m_ptr = 0;
      for (int i = 0; i < 8; i++) m_shadow[i] = 8'h00;
      e.led = 8'hFF; e.sg = 8'hFF; e.sel = 3'd0;
    end else begin
      d   = (m_n / SCAN_DIV) % 8;
      r   = (page ? 4 : 0) + d / 2;
      nib = (d % 2 == 1) ? m_shadow[r][7:4] : m_shadow[r][3:0];
      e.sg = hex_tab[nib];
      if (page && (d % 2 == 1)) e.sg[7] = 1'b0;
      e.led = ~(8'd1 << d);
      if (!hold) begin
        m_shadow[m_ptr] = regs[m_ptr];
        m_ptr = (m_ptr + 1) % 8;
      end
      m_n++;
      e.sel = 3'(m_ptr);
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("led_en", led_en, e.led);
      chk("seg", seg, e.sg);
      chk("rd_sel", {5'd0, rd_sel}, {5'd0, e.sel});
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    #1;
    chk("async_led_en", led_en, 8'hFF);
    chk("async_seg", seg, 8'hFF);
    chk("async_rd_sel", {5'd0, rd_sel}, 8'h00);
    run(2);
    clr = 1'b0;
  endtask

  initial begin
    clr  = 1'b1;
    page = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    run(3);
    clr = 1'b0;
    run(12);

    regs[0] = 8'h12; regs[1] = 8'h34; regs[2] = 8'h56; regs[3] = 8'h78;
    run(45);

    regs[4] = 8'hAB; regs[7] = 8'hF0; page = 1'b1;
    run(40);

    page = 1'b0; hold = 1'b1;
    run(2);
    regs[0] = 8'hFF;
    run(70);
    hold = 1'b0;
    run(45);

    run(5);
    clr_pulse();
    run(40);

    for (int it = 0; it < 2000; it++) begin
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)] = 8'($urandom);
      if ($urandom_range(0, 19) == 0) page = ~page;
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      if ($urandom_range(0, 299) == 0) clr_pulse();
      run(1);
    end

    hold = 1'b0;
    run(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
